// File: rtl/ysyx_22040386_mdu_pkg.sv
// Shared definitions for the RV64M multiply/divide unit: funct3 op codes,
// FSM state encoding and a 32-bit sign-extension helper.
package ysyx_22040386_mdu_pkg;

    // M-extension funct3 encodings
    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } mdu_state_e;

    // Callers truncate the 64-bit result to XLEN
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22040386_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle.
// i_start loads operands; the core then runs i_len steps. o_done is high during
// the final step and o_quotient/o_remainder carry that step's results, so the
// caller captures them on the same edge that completes the division.
module ysyx_22040386_div_core #(
    parameter int unsigned XLEN = 64,
    localparam int unsigned CW  = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [CW-1:0]   i_len,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvs;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_len;
    logic            r_run;

    logic [XLEN:0]   w_tmp;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;

    // One restoring step: shift in next dividend bit, trial-subtract divisor
    always_comb begin
        w_tmp     = {r_rem, r_quo[XLEN-1]};
        w_diff    = w_tmp - {1'b0, r_dvs};
        w_ge      = ~w_diff[XLEN];
        w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_tmp[XLEN-1:0];
        w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
    end

    assign o_done      = r_run && (r_cnt == r_len - CW'(1));
    assign o_quotient  = w_quo_nxt;
    assign o_remainder = w_rem_nxt;

    // Operand load on start, then iterate until the programmed length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= '0;
            r_len <= i_len;
            r_run <= 1'b1;
        end else if (r_run && (r_cnt != r_len)) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040386_muldiv.sv
// Iterative RV64M multiply/divide unit with valid/ready handshakes.
// Operands are converted to magnitudes at accept; the sign is fixed when the
// result is captured on entry to DONE. Division by zero and MIN/-1 bypass the
// iterative path and complete one cycle after accept.
// Build option: define YSYX_22040386_MUL_SINGLE_CYCLE_EN to compute the MUL
// family combinationally at accept instead of with the shift-add loop.
module ysyx_22040386_muldiv
    import ysyx_22040386_mdu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned PW = 2 * XLEN;

    // Word results are the low 32 bits sign-extended to XLEN
    function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v, input logic word);
        logic [63:0] s;
        s = sext32(v[31:0]);
        return word ? s[XLEN-1:0] : v;
    endfunction

    function automatic logic [XLEN-1:0] fin_mul(input logic [PW-1:0] p, input logic neg,
                                                input logic [2:0] o, input logic word);
        logic [PW-1:0] q;
        q = neg ? -p : p;
        if (word)             return word_fix(q[XLEN-1:0], 1'b1);
        else if (o == OpMul)  return q[XLEN-1:0];
        else                  return q[PW-1:XLEN];
    endfunction

    mdu_state_e r_state;
    mdu_state_e w_state_nxt;

    logic [2:0]      r_op;
    logic            r_word;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [CW-1:0]   r_len;
    logic [CW-1:0]   r_cnt;
    logic [PW-1:0]   r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [PW-1:0]   r_prod;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_word;
    logic            w_is_div;
    logic            w_sgn1;
    logic            w_sgn2;
    logic [63:0]     w_sx1;
    logic [63:0]     w_sx2;
    logic [63:0]     w_mw;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic            w_neg1;
    logic            w_neg2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic [CW-1:0]   w_len;
    logic [XLEN-1:0] w_min;
    logic            w_dvz;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_dvd;
    logic            w_div_done;
    logic [XLEN-1:0] w_div_q;
    logic [XLEN-1:0] w_div_r;
    logic [XLEN-1:0] w_quo_s;
    logic [XLEN-1:0] w_rem_s;
    logic [PW-1:0]   w_prod_nxt;
    logic            w_finish;

    // Operand preparation from the live inputs (used only on the accept edge)
    always_comb begin
        w_word   = (XLEN == 64) && is_word;
        w_is_div = op[2];
        w_sgn1   = (op != OpMulhu) && (op != OpDivu) && (op != OpRemu);
        w_sgn2   = (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
        w_sx1    = sext32(src1[31:0]);
        w_sx2    = sext32(src2[31:0]);
        w_mw     = sext32(32'h8000_0000);
        if (w_word) begin
            w_a   = w_sgn1 ? w_sx1[XLEN-1:0] : XLEN'(src1[31:0]);
            w_b   = w_sgn2 ? w_sx2[XLEN-1:0] : XLEN'(src2[31:0]);
            w_min = w_mw[XLEN-1:0];
        end else begin
            w_a   = src1;
            w_b   = src2;
            w_min = {1'b1, {(XLEN-1){1'b0}}};
        end
        w_neg1 = w_sgn1 && w_a[XLEN-1];
        w_neg2 = w_sgn2 && w_b[XLEN-1];
        w_mag1 = w_neg1 ? -w_a : w_a;
        w_mag2 = w_neg2 ? -w_b : w_b;
        w_len  = w_word ? CW'(32) : CW'(XLEN);
        // Left-align a word dividend so the core consumes its MSB first
        w_dvd  = w_word ? (w_mag1 << (XLEN - 32)) : w_mag1;

        w_dvz      = (w_b == '0);
        w_ovf      = w_sgn1 && (w_a == w_min) && (w_b == '1);
        w_special  = w_is_div && (w_dvz || w_ovf);
        if (op[1]) w_spec_res = word_fix(w_dvz ? w_a : '0, w_word);
        else       w_spec_res = word_fix(w_dvz ? '1 : w_a, w_word);
    end

`ifdef YSYX_22040386_MUL_SINGLE_CYCLE_EN
    logic [PW-1:0] w_prod_comb;

    // Whole MUL family resolved at accept; only special divides share this path
    always_comb begin
        w_prod_comb = PW'(w_mag1) * PW'(w_mag2);
        w_fast      = w_special || !w_is_div;
        w_fast_res  = w_is_div ? w_spec_res : fin_mul(w_prod_comb, w_neg1 ^ w_neg2, op, w_word);
    end
`else
    // Only special divides complete without iterating
    always_comb begin
        w_fast     = w_special;
        w_fast_res = w_spec_res;
    end
`endif

    ysyx_22040386_div_core #(
        .XLEN (XLEN)
    ) u_div_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_accept && w_is_div && !w_special),
        .i_len       (w_len),
        .i_dividend  (w_dvd),
        .i_divisor   (w_mag2),
        .o_done      (w_div_done),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    // Final-step values and sign fix-up for results captured on entry to DONE
    always_comb begin
        w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
        w_quo_s    = r_neg_q ? -w_div_q : w_div_q;
        w_rem_s    = r_neg_r ? -w_div_r : w_div_r;
        w_finish   = r_is_div ? w_div_done : (r_cnt == r_len - CW'(1));
    end

    // FSM next state and handshake outputs; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_fast ? StDone : StBusy;
                end
            end
            StBusy:  if (w_finish)  w_state_nxt = StDone;
            StDone:  if (out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (flush) begin
            w_state_nxt = StIdle;
            w_accept    = 1'b0;
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign result    = r_result;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    // Operand latch at accept, shift-add iteration and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_word   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= op;
            r_word   <= w_word;
            r_is_div <= w_is_div;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_len    <= w_len;
            r_cnt    <= '0;
            r_mcand  <= PW'(w_mag1);
            r_mplier <= w_mag2;
            r_prod   <= '0;
            if (w_fast) r_result <= w_fast_res;
        end else if ((r_state == StBusy) && !flush) begin
            r_cnt    <= r_cnt + CW'(1);
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_finish) begin
                r_result <= r_is_div ? word_fix(r_op[1] ? w_rem_s : w_quo_s, r_word)
                                     : fin_mul(w_prod_nxt, r_neg_q, r_op, r_word);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_muldiv.sv
// Scoreboard bench for ysyx_22040386_muldiv (XLEN=64).
module tb_ysyx_22040386_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic        is_word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    ysyx_22040386_muldiv #(
        .XLEN (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] val;
        logic [31:0] lat;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference RV64M semantics built from wide native arithmetic
    function automatic logic [63:0] ref_res(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] pa, pb, pp;
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q64, r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (!o[2]) begin
            if (w) begin
                q32 = a32 * b32;
                return sx(q32);
            end
            pa = (o == 3'b011) ? $signed({66'b0, a}) : $signed({{66{a[63]}}, a});
            pb = (o == 3'b000 || o == 3'b001) ? $signed({{66{b[63]}}, b}) : $signed({66'b0, b});
            pp = pa * pb;
            return (o == 3'b000) ? pp[63:0] : pp[127:64];
        end
        if (w) begin
            if (b32 == 0) begin
                q32 = '1; r32 = a32;
            end else if (!o[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0;
            end else if (!o[0]) begin
                q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            return sx(o[1] ? r32 : q32);
        end
        if (b == 0) begin
            q64 = '1; r64 = a;
        end else if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = '0;
        end else if (!o[0]) begin
            q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return o[1] ? r64 : q64;
    endfunction

    // Cycles from the accept cycle to the first cycle with out_valid
    function automatic int ref_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        if (o[2]) begin
            if (w ? (b[31:0] == 0) : (b == 0)) return 1;
            if (!o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                            : (a == 64'h8000_0000_0000_0000 && b == '1))) return 1;
            return w ? 33 : 65;
        end
`ifdef YSYX_22040386_MUL_SINGLE_CYCLE_EN
        return 1;
`else
        return w ? 33 : 65;
`endif
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int stall);
        exp_t e;
        string t;
        int cyc;
        logic busy_ok;
        e.val = exp;
        e.lat = ref_lat(o, w, a, b);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Inputs change after accept; the unit must have latched them
        in_valid = 1'b0; op = 3'($urandom); is_word = ~w;
        src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        cyc = 1;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".out_valid"}, out_valid, 1);
        chk({t, ".busy_ready"}, busy_ok, 1);
        chk({t, ".done_ready"}, in_ready, 0);
        chk({t, ".result"}, result, e.val);
        chk({t, ".latency"}, cyc, e.lat);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({t, ".hold_valid"}, out_valid, 1);
            chk({t, ".hold_result"}, result, e.val);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({t, ".drained"}, out_valid, 0);
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 40));
            2:       return -64'($urandom_range(1, 40));
            3:       return sx($urandom);
            default: return ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h0;
        endcase
    endfunction

    initial begin
        logic seen;
        logic [2:0] ro;
        logic rw;
        logic [63:0] ra, rb;

        #12;
        rst_n = 1'b1;
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.result", result, 0);

        run_op("mul_7x-3", 3'b000, 1'b0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        run_op("mulhu", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 0);
        run_op("mulh", 3'b001, 1'b0, '1, '1, 64'd0, 0);
        run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("div", 3'b100, 1'b0, -64'd7, 64'd2, -64'd3, 0);
        run_op("rem", 3'b110, 1'b0, -64'd7, 64'd2, -64'd1, 5);
        run_op("divu_z", 3'b101, 1'b0, 64'd100, 64'd0, '1, 0);
        run_op("remu_z", 3'b111, 1'b0, 64'd100, 64'd0, 64'd100, 0);
        run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1,
               64'h8000_0000_0000_0000, 0);
        run_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0);
        run_op("divuw", 3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 0);
        run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("mul_z", 3'b000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 0);

        // Flush at BUSY cycle 10 while a would-be special request is offered
        @(negedge clk);
        op = 3'b100; is_word = 1'b0; src1 = 64'd1000; src2 = 64'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'b101; src2 = 64'd0;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.in_ready", in_ready, 1);
        chk("flush.out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush.no_result", seen, 0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 3'b100; is_word = 1'b0; src1 = 64'd999; src2 = 64'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rst.no_result", seen, 0);

        for (int i = 0; i < 14; i++) begin
            ro = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            if (rw && !ro[2]) ro = 3'b000;
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rand%0d_op%0d_w%0d", i, ro, rw), ro, rw, ra, rb,
                   ref_res(ro, rw, ra, rb), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
